// File: rtl/aha_tlx_training_ctrl_pkg.sv
// Shared definitions for the TLX training controller.
// State encodings, lane data width, retry field width, default pattern.
package aha_tlx_training_ctrl_pkg;

  localparam int LANE_DW = 32;
  localparam int RETRY_W = 2;
  localparam logic [31:0] DEFAULT_SEQUENCE = 32'h5A6B7C8D;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_STRT = 3'd2,
    ST_WAIT = 3'd3,
    ST_EVAL = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

  function automatic logic [RETRY_W-1:0] sat_retry(
    input logic [7:0] r
  );
    logic [7:0] top;
    top = 8'((1 << RETRY_W) - 1);
    return (r > top) ? top[RETRY_W-1:0] : r[RETRY_W-1:0];
  endfunction

endpackage

// File: rtl/aha_tlx_train_watchdog.sv
// WAIT-state watchdog: clear/enable counter that flags expiry.
// Only instantiated when AHA_TLX_TRAIN_TIMEOUT_EN is defined.
module aha_tlx_train_watchdog #(
  parameter int LIMIT = 4096
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  // Fires on the LIMIT-th enabled cycle after a clear.
  assign expire = enable && (count == CW'(LIMIT - 1));

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/aha_tlx_training_ctrl.sv
// TLX link training sequencer: clear/start/wait/grade with per-lane retry.
// Optional WAIT watchdog enabled by defining AHA_TLX_TRAIN_TIMEOUT_EN.
module aha_tlx_training_ctrl
  import aha_tlx_training_ctrl_pkg::*;
#(
  parameter int NUM_LANES      = 4,
  parameter int MAX_RETRIES    = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                         CLK,
  input  logic                         RESETn,
  input  logic                         TRAIN_REQ,
  input  logic [NUM_LANES-1:0]         CFG_LANE_EN,
  input  logic [31:0]                  CFG_SEQUENCE,
  input  logic [31:0]                  CFG_LENGTH,
  input  logic [31:0]                  CFG_THRESHOLD,
  output logic [NUM_LANES-1:0]         LANE_CLEAR,
  output logic [NUM_LANES-1:0]         LANE_START,
  output logic [31:0]                  LANE_SEQUENCE,
  output logic [31:0]                  LANE_LENGTH,
  output logic                         LANE_AUTO_STOP,
  input  logic [NUM_LANES-1:0]         LANE_DONE,
  input  logic [LANE_DW*NUM_LANES-1:0] LANE_MATCH_COUNT,
  output logic                         TRAIN_BUSY,
  output logic                         TRAIN_DONE,
  output logic [NUM_LANES-1:0]         LANE_PASS,
  output logic [RETRY_W-1:0]           RETRY_COUNT,
  output logic                         TIMEOUT_FLAG
);

  state_t               state, state_n;
  logic [NUM_LANES-1:0] pending, pending_n;
  logic [NUM_LANES-1:0] pass_q, pass_n;
  logic [NUM_LANES-1:0] grade;
  logic [7:0]           retries, retries_n;
  logic                 tflag, tflag_n;
  logic                 accept;
  logic [31:0]          thr;
  logic                 expire;
  logic                 all_done;

`ifdef AHA_TLX_TRAIN_TIMEOUT_EN
  aha_tlx_train_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .CLK    (CLK),
    .RESETn (RESETn),
    .clear  (state == ST_STRT),
    .enable (state == ST_WAIT),
    .expire (expire)
  );
`else
  // No watchdog: WAIT is unbounded and the flag can never set.
  assign expire = (TIMEOUT_CYCLES < 0);
`endif

  assign all_done = ((LANE_DONE & pending) == pending);

  always_comb begin
    grade = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      grade[i] = pending[i] && LANE_DONE[i] &&
        (LANE_MATCH_COUNT[i*LANE_DW +: LANE_DW] >= thr);
    end
  end

  always_comb begin
    state_n   = state;
    pending_n = pending;
    pass_n    = pass_q;
    retries_n = retries;
    tflag_n   = tflag;
    accept    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (TRAIN_REQ) begin
          accept    = 1'b1;
          pending_n = CFG_LANE_EN;
          pass_n    = '0;
          retries_n = '0;
          tflag_n   = 1'b0;
          state_n   = (CFG_LANE_EN == '0) ? ST_FIN : ST_CLR;
        end
      end
      ST_CLR:  state_n = ST_STRT;
      ST_STRT: state_n = ST_WAIT;
      ST_WAIT: begin
        if (all_done) begin
          state_n = ST_EVAL;
        end else if (expire) begin
          tflag_n = 1'b1;
          state_n = ST_EVAL;
        end
      end
      ST_EVAL: begin
        pass_n    = pass_q | grade;
        pending_n = pending & ~grade;
        if (pending_n == '0 || retries == 8'(MAX_RETRIES)) begin
          state_n = ST_FIN;
        end else begin
          retries_n = retries + 8'd1;
          state_n   = ST_CLR;
        end
      end
      ST_FIN:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state   <= ST_IDLE;
      pending <= '0;
      pass_q  <= '0;
      retries <= '0;
      tflag   <= 1'b0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      pass_q  <= pass_n;
      retries <= retries_n;
      tflag   <= tflag_n;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      LANE_SEQUENCE <= '0;
      LANE_LENGTH   <= '0;
      thr           <= '0;
    end else if (accept) begin
      LANE_SEQUENCE <= CFG_SEQUENCE;
      LANE_LENGTH   <= CFG_LENGTH;
      thr           <= CFG_THRESHOLD;
    end
  end

  assign LANE_CLEAR     = (state == ST_CLR) ? pending : '0;
  assign LANE_START     = (state == ST_STRT) ? pending : '0;
  assign LANE_AUTO_STOP = 1'b1;
  assign TRAIN_BUSY     = (state != ST_IDLE);
  assign TRAIN_DONE     = (state == ST_FIN);
  assign LANE_PASS      = pass_q;
  assign RETRY_COUNT    = sat_retry(retries);
  assign TIMEOUT_FLAG   = tflag;

endmodule
